// File: rtl/pc_src_reg_pkg.sv
// Shared definitions for the PC source selector: branch condition encodings
// and the default exception handler address.
package pc_src_reg_pkg;

    localparam logic [1:0] COND_EQ  = 2'd0;  // zero
    localparam logic [1:0] COND_NE  = 2'd1;  // !zero
    localparam logic [1:0] COND_LEZ = 2'd2;  // zero | neg
    localparam logic [1:0] COND_GT  = 2'd3;  // !zero & !neg

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h04C4_B4B4;

endpackage

// File: rtl/pc_src_mux.sv
// Combinational NSRC-way next-PC selector. One slot is overridden with the
// exception vector; o_valid is low when the select is outside 0..NSRC-1.
module pc_src_mux #(
    parameter int              WIDTH      = 32,
    parameter int              NSRC       = 6,
    parameter int              SEL_W      = 3,
    parameter int              EXC_SLOT   = 3,
    parameter logic [WIDTH-1:0] EXC_VECTOR = '0
) (
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [NSRC*WIDTH-1:0] i_src_data,
    output logic [WIDTH-1:0]      o_data,
    output logic                  o_valid,
    output logic                  o_is_exc
);

    always_comb begin
        o_data   = '0;
        o_valid  = 1'b0;
        o_is_exc = 1'b0;
        // Every select bit takes part in the match, so high bits cannot alias a slot.
        for (int i = 0; i < NSRC; i++) begin
            if (i_sel == SEL_W'(i)) begin
                o_data  = i_src_data[i*WIDTH +: WIDTH];
                o_valid = 1'b1;
            end
        end
        if (i_sel == SEL_W'(EXC_SLOT)) begin
            o_data   = EXC_VECTOR;
            o_valid  = 1'b1;
            o_is_exc = 1'b1;
        end
    end

endmodule

// File: rtl/pc_src_reg.sv
// PC/EPC register block: condition decode, write priority (bad select,
// misalignment trap, normal commit) and the status pulses/flags.
module pc_src_reg
    import pc_src_reg_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               NSRC       = 6,
    parameter int               SEL_W      = 3,
    parameter int               EXC_SLOT   = 3,
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(EXC_VECTOR_DEFAULT),
    parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SEL_W-1:0]      src_sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic                  pc_write,
    input  logic                  pc_write_cond,
    input  logic [1:0]            cond_mode,
    input  logic                  zero,
    input  logic                  neg,
    input  logic                  epc_write,
    input  logic                  err_clear,
    output logic [WIDTH-1:0]      pc_out,
    output logic [WIDTH-1:0]      epc_out,
    output logic                  pc_changed,
    output logic                  misalign_trap,
    output logic                  bad_sel_err
);

    logic [WIDTH-1:0] w_target;
    logic             w_valid;
    logic             w_is_exc;
    logic             w_cond_true;
    logic             w_do_wr;
    logic             w_misalign;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_pc_changed;
    logic             r_misalign_trap;
    logic             r_bad_sel_err;

    pc_src_mux #(
        .WIDTH      (WIDTH),
        .NSRC       (NSRC),
        .SEL_W      (SEL_W),
        .EXC_SLOT   (EXC_SLOT),
        .EXC_VECTOR (EXC_VECTOR)
    ) u_mux (
        .i_sel      (src_sel),
        .i_src_data (src_data),
        .o_data     (w_target),
        .o_valid    (w_valid),
        .o_is_exc   (w_is_exc)
    );

    always_comb begin
        w_cond_true = 1'b0;
        case (cond_mode)
            COND_EQ:  w_cond_true = zero;
            COND_NE:  w_cond_true = ~zero;
            COND_LEZ: w_cond_true = zero | neg;
            COND_GT:  w_cond_true = ~zero & ~neg;
            default:  w_cond_true = 1'b0;
        endcase
    end

    assign w_do_wr    = pc_write | (pc_write_cond & w_cond_true);
    // The exception vector is trusted and never trapped on alignment.
    assign w_misalign = w_valid & ~w_is_exc & (|w_target[1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc            <= RESET_PC;
            r_epc           <= '0;
            r_pc_changed    <= 1'b0;
            r_misalign_trap <= 1'b0;
            r_bad_sel_err   <= 1'b0;
        end else begin
            r_pc_changed    <= 1'b0;
            r_misalign_trap <= 1'b0;
            if (err_clear) begin
                r_bad_sel_err <= 1'b0;
            end
            if (epc_write) begin
                r_epc <= src_data[WIDTH-1:0];
            end
            // Later assignments override: set beats clear, trap EPC beats epc_write.
            if (w_do_wr) begin
                if (!w_valid) begin
                    r_bad_sel_err <= 1'b1;
                end else if (w_misalign) begin
                    r_pc            <= EXC_VECTOR;
                    r_epc           <= r_pc;
                    r_misalign_trap <= 1'b1;
                    r_pc_changed    <= 1'b1;
                end else begin
                    r_pc         <= w_target;
                    r_pc_changed <= 1'b1;
                end
            end
        end
    end

    assign pc_out        = r_pc;
    assign epc_out       = r_epc;
    assign pc_changed    = r_pc_changed;
    assign misalign_trap = r_misalign_trap;
    assign bad_sel_err   = r_bad_sel_err;

endmodule

// File: tb/tb_pc_src_reg.sv
// Bench for pc_src_reg: directed scenarios plus randomized traffic checked
// against a slot-array reference model of the PC/EPC behaviour.
module tb_pc_src_reg;

    localparam int          WIDTH = 32;
    localparam int          NSRC  = 6;
    localparam int          SEL_W = 3;
    localparam logic [31:0] EXC   = 32'h04C4_B4B4;

    logic                  clk;
    logic                  reset;
    logic [SEL_W-1:0]      src_sel;
    logic [NSRC*WIDTH-1:0] src_data;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic [1:0]            cond_mode;
    logic                  zero;
    logic                  neg;
    logic                  epc_write;
    logic                  err_clear;
    logic [WIDTH-1:0]      pc_out;
    logic [WIDTH-1:0]      epc_out;
    logic                  pc_changed;
    logic                  misalign_trap;
    logic                  bad_sel_err;

    pc_src_reg dut (
        .clk           (clk),
        .reset         (reset),
        .src_sel       (src_sel),
        .src_data      (src_data),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond_mode     (cond_mode),
        .zero          (zero),
        .neg           (neg),
        .epc_write     (epc_write),
        .err_clear     (err_clear),
        .pc_out        (pc_out),
        .epc_out       (epc_out),
        .pc_changed    (pc_changed),
        .misalign_trap (misalign_trap),
        .bad_sel_err   (bad_sel_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [31:0] slot [NSRC];
    logic [31:0] m_pc, m_epc;
    logic        m_chg, m_trap, m_bad;
    logic [66:0] got, want;

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_chg = 0; m_trap = 0; m_bad = 0;
    endtask

    function automatic bit cond_holds(input int mode, input bit z, input bit n);
        case (mode)
            0: return z;
            1: return !z;
            2: return z || n;
            default: return !z && !n;
        endcase
    endfunction

    // Drive one cycle of inputs, advance the model, and land #1 after the edge.
    task automatic step(input int sel, input bit pw, input bit pwc, input int cm,
                        input bit z, input bit n, input bit ew, input bit ec);
        logic [31:0] tgt;
        bit wr;
        for (int i = 0; i < NSRC; i++) src_data[i*WIDTH +: WIDTH] = slot[i];
        src_sel = SEL_W'(sel); pc_write = pw; pc_write_cond = pwc;
        cond_mode = 2'(cm); zero = z; neg = n; epc_write = ew; err_clear = ec;
        wr = pw || (pwc && cond_holds(cm, z, n));
        m_chg = 0; m_trap = 0;
        if (ec) m_bad = 0;
        if (ew) m_epc = slot[0];
        if (wr) begin
            if (sel >= NSRC) m_bad = 1;
            else begin
                tgt = (sel == 3) ? EXC : slot[sel];
                if (sel != 3 && (tgt % 4) != 0) begin
                    m_epc = m_pc; m_pc = EXC; m_trap = 1; m_chg = 1;
                end else begin
                    m_pc = tgt; m_chg = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        pc_write = 0; pc_write_cond = 0; epc_write = 0; err_clear = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src_sel = '0; src_data = '0; pc_write = 0; pc_write_cond = 0;
        cond_mode = '0; zero = 0; neg = 0; epc_write = 0; err_clear = 0;
        for (int i = 0; i < NSRC; i++) slot[i] = 32'h0;
        model_reset();
        #3;
        got = {pc_out, epc_out, pc_changed, misalign_trap, bad_sel_err};
        if (got !== 67'h0) begin
            n_bad++; $display("FAIL reset: got %h want %h", got, 67'h0);
        end
        n_cmp++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_uncond();
        slot[1] = 32'h0000_0040;
        step(1, 1, 0, 0, 0, 0, 0, 0);
        if (pc_out !== 32'h40 || pc_changed !== 1'b1) begin
            n_bad++; $display("FAIL uncond: got pc=%h chg=%b want pc=00000040 chg=1", pc_out, pc_changed);
        end
        n_cmp++;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        if (pc_out !== 32'h40 || pc_changed !== 1'b0) begin
            n_bad++; $display("FAIL uncond_idle: got pc=%h chg=%b want pc=00000040 chg=0", pc_out, pc_changed);
        end
        n_cmp++;
    endtask

    task automatic test_branch();
        int k;
        k = 0;
        for (int m = 0; m < 4; m++) begin
            for (int f = 0; f < 4; f++) begin
                slot[2] = 32'h100 + 32'(k * 16);
                step(2, 0, 1, m, f[0], f[1], 0, 0);
                got  = {pc_out, epc_out, pc_changed, misalign_trap, bad_sel_err};
                want = {m_pc, m_epc, m_chg, m_trap, m_bad};
                if (got !== want) begin
                    n_bad++; $display("FAIL branch m=%0d z=%0d n=%0d: got %h want %h", m, f[0], f[1], got, want);
                end
                n_cmp++;
                k++;
            end
        end
        // unconditional write dominates a false condition
        slot[2] = 32'h0000_0200;
        step(2, 1, 1, 0, 0, 0, 0, 0);
        if (pc_out !== 32'h200 || pc_changed !== 1'b1) begin
            n_bad++; $display("FAIL pw_dominates: got pc=%h chg=%b want pc=00000200 chg=1", pc_out, pc_changed);
        end
        n_cmp++;
    endtask

    task automatic test_exc_slot();
        slot[3] = 32'hDEAD_BEEF;
        step(3, 1, 0, 0, 0, 0, 0, 0);
        if (pc_out !== EXC || pc_changed !== 1'b1 || misalign_trap !== 1'b0) begin
            n_bad++; $display("FAIL exc_slot: got pc=%h chg=%b trap=%b want pc=%h chg=1 trap=0",
                              pc_out, pc_changed, misalign_trap, EXC);
        end
        n_cmp++;
    endtask

    task automatic test_misalign();
        slot[1] = 32'h0000_0040;
        step(1, 1, 0, 0, 0, 0, 0, 0);
        slot[0] = 32'h0000_0102;
        step(0, 1, 0, 0, 0, 0, 1, 0);
        if (pc_out !== EXC || epc_out !== 32'h40 || misalign_trap !== 1'b1 || pc_changed !== 1'b1) begin
            n_bad++; $display("FAIL misalign: got pc=%h epc=%h trap=%b chg=%b want pc=%h epc=00000040 trap=1 chg=1",
                              pc_out, epc_out, misalign_trap, pc_changed, EXC);
        end
        n_cmp++;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        if (misalign_trap !== 1'b0 || epc_out !== 32'h40) begin
            n_bad++; $display("FAIL misalign_pulse: got trap=%b epc=%h want trap=0 epc=00000040", misalign_trap, epc_out);
        end
        n_cmp++;
        slot[0] = 32'h1234_5678;
        step(0, 0, 0, 0, 0, 0, 1, 0);
        if (epc_out !== 32'h1234_5678 || pc_out !== EXC) begin
            n_bad++; $display("FAIL epc_write: got epc=%h pc=%h want epc=12345678 pc=%h", epc_out, pc_out, EXC);
        end
        n_cmp++;
    endtask

    task automatic test_bad_sel();
        logic [31:0] hold;
        hold = m_pc;
        step(7, 1, 0, 0, 0, 0, 0, 0);
        if (pc_out !== hold || bad_sel_err !== 1'b1 || pc_changed !== 1'b0) begin
            n_bad++; $display("FAIL bad_sel: got pc=%h err=%b chg=%b want pc=%h err=1 chg=0",
                              pc_out, bad_sel_err, pc_changed, hold);
        end
        n_cmp++;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        if (bad_sel_err !== 1'b1) begin
            n_bad++; $display("FAIL bad_sel_sticky: got %b want 1", bad_sel_err);
        end
        n_cmp++;
        step(0, 0, 0, 0, 0, 0, 0, 1);
        if (bad_sel_err !== 1'b0) begin
            n_bad++; $display("FAIL err_clear: got %b want 0", bad_sel_err);
        end
        n_cmp++;
        step(6, 1, 0, 0, 0, 0, 0, 1);
        if (bad_sel_err !== 1'b1 || pc_out !== hold) begin
            n_bad++; $display("FAIL set_beats_clear: got err=%b pc=%h want err=1 pc=%h", bad_sel_err, pc_out, hold);
        end
        n_cmp++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NSRC; i++)
                slot[i] = $urandom() & (($urandom_range(0, 2) != 0) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
            step($urandom_range(0, 7), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            got  = {pc_out, epc_out, pc_changed, misalign_trap, bad_sel_err};
            want = {m_pc, m_epc, m_chg, m_trap, m_bad};
            if (got !== want) begin
                n_bad++; $display("FAIL random c=%0d: got %h want %h", c, got, want);
            end
            n_cmp++;
        end
    endtask

    task automatic test_reset_mid();
        slot[1] = 32'h0000_0080;
        slot[0] = 32'h0000_0055;
        step(1, 1, 0, 0, 0, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        got = {pc_out, epc_out, pc_changed, misalign_trap, bad_sel_err};
        if (got !== 67'h0) begin
            n_bad++; $display("FAIL reset_mid: got %h want %h", got, 67'h0);
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        step(1, 1, 0, 0, 0, 0, 0, 0);
        if (pc_out !== 32'h80 || pc_changed !== 1'b1) begin
            n_bad++; $display("FAIL after_reset: got pc=%h chg=%b want pc=00000080 chg=1", pc_out, pc_changed);
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_uncond();
        test_branch();
        test_exc_slot();
        test_misalign();
        test_bad_sel();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
